axis_pattern_checker: RTL and testbench

AXI4-Stream sink that verifies the incrementing-counter frames produced by the pattern generator after a DMA loopback (MM2S output). Aligns to frame boundaries, then checks every beat for data continuity, `tlast` placement and `tkeep`. Exposes frame/beat/error counters and first-error capture to PS-readable registers for throughput and integrity tests.

---
 rtl/axis_pattern_pkg.sv | 24 ++
 rtl/sat_counter.sv | 28 ++
 rtl/axis_pattern_checker.sv | 173 +++++++++++++++++
 tb/tb_axis_pattern_checker.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pattern_pkg.sv
// Shared definitions for the AXI4-Stream pattern generator and checker.
// State encoding, error flag bit positions and frame sizing helpers.
package axis_pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    localparam int ERR_DATA = 0;
    localparam int ERR_LAST = 1;
    localparam int ERR_KEEP = 2;
    localparam int ERR_BITS = 3;

    function automatic int frame_beats(input int frame_bytes, input int data_width);
        return frame_bytes / (data_width / 8);
    endfunction

    function automatic int beat_idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear; optionally holds at all-ones.
// Reset is synchronous and active-low.
module sat_counter #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = SATURATE && (&count);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/axis_pattern_checker.sv
// AXI4-Stream sink checking incrementing-counter frames after loopback.
// Aligns on tlast, then checks data continuity, tlast position and tkeep.
module axis_pattern_checker
    import axis_pattern_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_BYTES = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int ERR_WIDTH   = 16
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_aresetn,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    output logic                    locked,
    output logic [CNT_WIDTH-1:0]    frame_count,
    output logic [CNT_WIDTH-1:0]    beat_count,
    output logic [ERR_WIDTH-1:0]    error_count,
    output logic [ERR_BITS-1:0]     err_flags,
    output logic [DATA_WIDTH-1:0]   first_err_exp,
    output logic [DATA_WIDTH-1:0]   first_err_got
);

    localparam int FRAME_BEATS = frame_beats(FRAME_BYTES, DATA_WIDTH);
    localparam int IDX_W       = beat_idx_width(FRAME_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BEATS - 1);

    state_e state_q;
    state_e state_d;

    logic [DATA_WIDTH-1:0] expected;
    logic [IDX_W-1:0]      beat_idx;
    logic                  captured;

    logic beat;
    logic sync_beat;
    logic chk_beat;
    logic data_err;
    logic last_err;
    logic keep_err;
    logic any_err;
    logic idx_at_last;
    logic [DATA_WIDTH-1:0] next_exp;

    // tready depends on the state register only
    assign s_axis_tready = (state_q != ST_IDLE);
    assign locked        = (state_q == ST_CHECK);

    assign beat      = s_axis_tvalid && s_axis_tready;
    assign sync_beat = beat && (state_q == ST_SYNC);
    assign chk_beat  = beat && (state_q == ST_CHECK);

    assign idx_at_last = (beat_idx == LAST_IDX);
    assign next_exp    = s_axis_tdata + DATA_WIDTH'(1);

    assign data_err = (s_axis_tdata != expected);
    assign last_err = (s_axis_tlast != idx_at_last);
    assign keep_err = !(&s_axis_tkeep);
    assign any_err  = data_err || last_err || keep_err;

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (beat && s_axis_tlast) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Re-seeding on every beat keeps one bad beat from cascading
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            expected <= '0;
            beat_idx <= '0;
        end else if (sync_beat && s_axis_tlast) begin
            expected <= next_exp;
            beat_idx <= '0;
        end else if (chk_beat) begin
            expected <= next_exp;
            if (s_axis_tlast || idx_at_last) begin
                beat_idx <= '0;
            end else begin
                beat_idx <= beat_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            err_flags <= '0;
        end else if (clear) begin
            err_flags <= '0;
        end else if (chk_beat) begin
            err_flags[ERR_DATA] <= err_flags[ERR_DATA] | data_err;
            err_flags[ERR_LAST] <= err_flags[ERR_LAST] | last_err;
            err_flags[ERR_KEEP] <= err_flags[ERR_KEEP] | keep_err;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            captured      <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (clear) begin
            captured      <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (chk_beat && data_err && !captured) begin
            captured      <= 1'b1;
            first_err_exp <= expected;
            first_err_got <= s_axis_tdata;
        end
    end

    sat_counter #(
        .WIDTH    (CNT_WIDTH),
        .SATURATE (1'b0)
    ) u_frame_cnt (
        .clk   (s_axis_aclk),
        .rst_n (s_axis_aresetn),
        .clear (clear),
        .inc   (chk_beat && s_axis_tlast),
        .count (frame_count)
    );

    sat_counter #(
        .WIDTH    (CNT_WIDTH),
        .SATURATE (1'b0)
    ) u_beat_cnt (
        .clk   (s_axis_aclk),
        .rst_n (s_axis_aresetn),
        .clear (clear),
        .inc   (chk_beat),
        .count (beat_count)
    );

    sat_counter #(
        .WIDTH    (ERR_WIDTH),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .clk   (s_axis_aclk),
        .rst_n (s_axis_aresetn),
        .clear (clear),
        .inc   (chk_beat && any_err),
        .count (error_count)
    );

endmodule

// File: tb/tb_axis_pattern_checker.sv
// Directed self-checking bench for axis_pattern_checker.
module tb_axis_pattern_checker;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        clear;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [3:0]  tkeep;
    logic        locked;
    logic [31:0] frame_count;
    logic [31:0] beat_count;
    logic [15:0] error_count;
    logic [2:0]  err_flags;
    logic [31:0] first_err_exp;
    logic [31:0] first_err_got;

    int tests = 0;
    int fails = 0;
    logic [31:0] d;

    always #5 clk = ~clk;

    axis_pattern_checker #(
        .DATA_WIDTH  (32),
        .FRAME_BYTES (32),
        .CNT_WIDTH   (32),
        .ERR_WIDTH   (16)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (aresetn),
        .enable         (enable),
        .clear          (clear),
        .s_axis_tdata   (tdata),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .s_axis_tlast   (tlast),
        .s_axis_tkeep   (tkeep),
        .locked         (locked),
        .frame_count    (frame_count),
        .beat_count     (beat_count),
        .error_count    (error_count),
        .err_flags      (err_flags),
        .first_err_exp  (first_err_exp),
        .first_err_got  (first_err_got)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input logic l,
                        input logic [3:0] k, input logic clr);
        tdata  = v;
        tlast  = l;
        tkeep  = k;
        clear  = clr;
        tvalid = 1'b1;
        tests++;
        if (tready !== 1'b1) begin
            fails++;
            $display("FAIL send_ready got %b exp 1", tready);
        end
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
        tkeep  = 4'hF;
        clear  = 1'b0;
    endtask

    task automatic frame(input int n, input int last_at, input int bad_idx,
                         input logic [31:0] bad_val, input int keep_idx,
                         input int gap);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            v = (i == bad_idx) ? bad_val : d;
            send(v, i == last_at, (i == keep_idx) ? 4'b0111 : 4'hF, 1'b0);
            d = v + 32'd1;
            if (gap != 0 && (i % 2) == 0) repeat ((i % 3) + 1) tick();
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic restart();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        tkeep   = 4'hF;
        tdata   = '0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
        tests++;
        if (tready !== 1'b0) begin
            fails++; $display("FAIL reset_tready got %b exp 0", tready);
        end
        tests++;
        if (locked !== 1'b0) begin
            fails++; $display("FAIL reset_locked got %b exp 0", locked);
        end
        tests++;
        if ({frame_count, beat_count, error_count} !== 80'd0) begin
            fails++;
            $display("FAIL reset_counts got %0d/%0d/%0d exp 0/0/0",
                     frame_count, beat_count, error_count);
        end
        tests++;
        if ({err_flags, first_err_exp, first_err_got} !== 67'd0) begin
            fails++;
            $display("FAIL reset_flags got %b %h %h exp 0",
                     err_flags, first_err_exp, first_err_got);
        end
    endtask

    task automatic test_sync_midframe();
        enable = 1'b1;
        tick();
        tests++;
        if (tready !== 1'b1) begin
            fails++; $display("FAIL enable_tready got %b exp 1", tready);
        end
        for (int i = 0; i < 3; i++) send(32'd5 + 32'(i), 1'b0, 4'hF, 1'b0);
        tests++;
        if (locked !== 1'b0) begin
            fails++; $display("FAIL sync_prelock got %b exp 0", locked);
        end
        send(32'd8, 1'b1, 4'hF, 1'b0);
        d = 32'd9;
        tests++;
        if (locked !== 1'b1 || beat_count !== 32'd0) begin
            fails++;
            $display("FAIL sync_lock got %b/%0d exp 1/0", locked, beat_count);
        end
        for (int f = 0; f < 10; f++) frame(8, 7, -1, '0, -1, 0);
        tests++;
        if (frame_count !== 32'd10 || beat_count !== 32'd80) begin
            fails++;
            $display("FAIL clean_counts got %0d/%0d exp 10/80",
                     frame_count, beat_count);
        end
        tests++;
        if (error_count !== 16'd0 || err_flags !== 3'b000) begin
            fails++;
            $display("FAIL clean_errors got %0d/%b exp 0/000",
                     error_count, err_flags);
        end
    endtask

    task automatic test_data_corrupt();
        restart();
        pulse_clear();
        tests++;
        if (frame_count !== 32'd0 || first_err_got !== 32'd0) begin
            fails++;
            $display("FAIL clear_zero got %0d/%h exp 0/0",
                     frame_count, first_err_got);
        end
        send(32'd4, 1'b1, 4'hF, 1'b0);
        d = 32'd5;
        frame(8, 7, -1, '0, -1, 0);
        frame(8, 7, 5, 32'hFF, -1, 0);
        frame(8, 7, -1, '0, -1, 0);
        tests++;
        if (error_count !== 16'd1 || err_flags !== 3'b001) begin
            fails++;
            $display("FAIL corrupt_err got %0d/%b exp 1/001",
                     error_count, err_flags);
        end
        tests++;
        if (first_err_exp !== 32'h12 || first_err_got !== 32'hFF) begin
            fails++;
            $display("FAIL corrupt_capture got %h/%h exp 12/ff",
                     first_err_exp, first_err_got);
        end
        tests++;
        if (frame_count !== 32'd3 || beat_count !== 32'd24) begin
            fails++;
            $display("FAIL corrupt_counts got %0d/%0d exp 3/24",
                     frame_count, beat_count);
        end
        frame(8, 7, 2, 32'hAB, -1, 0);
        tests++;
        if (error_count !== 16'd2 || first_err_got !== 32'hFF) begin
            fails++;
            $display("FAIL capture_hold got %0d/%h exp 2/ff",
                     error_count, first_err_got);
        end
    endtask

    task automatic test_tlast();
        pulse_clear();
        frame(8, -1, -1, '0, -1, 0);
        frame(7, 6, -1, '0, -1, 0);
        frame(8, 7, -1, '0, -1, 0);
        tests++;
        if (error_count !== 16'd2 || err_flags !== 3'b010) begin
            fails++;
            $display("FAIL tlast_err got %0d/%b exp 2/010",
                     error_count, err_flags);
        end
        tests++;
        if (frame_count !== 32'd2 || beat_count !== 32'd23) begin
            fails++;
            $display("FAIL tlast_counts got %0d/%0d exp 2/23",
                     frame_count, beat_count);
        end
    endtask

    task automatic test_tkeep_gaps();
        pulse_clear();
        frame(8, 7, -1, '0, 3, 1);
        frame(8, 7, -1, '0, -1, 1);
        tests++;
        if (error_count !== 16'd1 || err_flags !== 3'b100) begin
            fails++;
            $display("FAIL tkeep_err got %0d/%b exp 1/100",
                     error_count, err_flags);
        end
        tests++;
        if (frame_count !== 32'd2 || beat_count !== 32'd16) begin
            fails++;
            $display("FAIL gap_counts got %0d/%0d exp 2/16",
                     frame_count, beat_count);
        end
        enable = 1'b0;
        tick();
        tests++;
        if (tready !== 1'b0 || locked !== 1'b0 || beat_count !== 32'd16) begin
            fails++;
            $display("FAIL disable got %b/%b/%0d exp 0/0/16",
                     tready, locked, beat_count);
        end
    endtask

    task automatic test_clear_reset();
        restart();
        send(d, 1'b1, 4'hF, 1'b0);
        d = d + 32'd1;
        send(d + 32'd5, 1'b0, 4'hF, 1'b1);
        d = d + 32'd6;
        tests++;
        if ({frame_count, beat_count, error_count} !== 80'd0) begin
            fails++;
            $display("FAIL clear_wins got %0d/%0d/%0d exp 0/0/0",
                     frame_count, beat_count, error_count);
        end
        tests++;
        if ({err_flags, first_err_exp, first_err_got} !== 67'd0
            || locked !== 1'b1) begin
            fails++;
            $display("FAIL clear_flags got %b %h %h lock %b exp 0 lock 1",
                     err_flags, first_err_exp, first_err_got, locked);
        end
        frame(2, -1, -1, '0, -1, 0);
        aresetn = 1'b0;
        enable  = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        repeat (3) tick();
        tests++;
        if (tready !== 1'b0 || locked !== 1'b0 || beat_count !== 32'd0
            || error_count !== 16'd0) begin
            fails++;
            $display("FAIL midreset got %b/%b/%0d/%0d exp 0/0/0/0",
                     tready, locked, beat_count, error_count);
        end
        enable = 1'b1;
        tick();
        tests++;
        if (tready !== 1'b1 || locked !== 1'b0) begin
            fails++;
            $display("FAIL reenable got %b/%b exp 1/0", tready, locked);
        end
        frame(5, 4, -1, '0, -1, 0);
        frame(8, 7, -1, '0, -1, 0);
        tests++;
        if (frame_count !== 32'd1 || beat_count !== 32'd8
            || error_count !== 16'd0) begin
            fails++;
            $display("FAIL realign got %0d/%0d/%0d exp 1/8/0",
                     frame_count, beat_count, error_count);
        end
    endtask

    initial begin
        d = '0;
        test_reset();
        test_sync_midframe();
        test_data_corrupt();
        test_tlast();
        test_tkeep_gaps();
        test_clear_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
